// File: rtl/gonso_pixel_renderer.sv
// Wishbone-controlled renderer that rasterizes a 64x64 shaded disc and streams
// one grayscale pixel per strobe onto the user I/O pads.
module gonso_pixel_renderer #(
  parameter int CLKS_PER_PIXEL = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [8:0]  io_out,
  output logic [8:0]  io_oeb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  RELOAD = 8'(CLKS_PER_PIXEL - 1);
  localparam logic [12:0] LAST   = 13'd4096;

  state_t      state_r, state_nx_s;
  logic [12:0] idx_r;
  logic [7:0]  div_r;
  logic        ack_r;
  logic [31:0] dat_r;
  logic [8:0]  io_r;
  logic        hit_s, req_s, wr_ctrl_s, start_s, emit_s;
  logic [11:0] pix_s;
  logic [7:0]  color_s;
  logic [31:0] rd_s;
  logic        unused_s;

  // Shade for raster index pix: bright at the centre, fading out to radius 24.
  function automatic logic [7:0] shade_f(input logic [11:0] pix);
    logic signed [12:0] dx, dy;
    logic [12:0]        d2;
    dx = $signed({7'd0, pix[5:0]}) - 13'sd32;
    dy = $signed({7'd0, pix[11:6]}) - 13'sd32;
    d2 = $unsigned(dx * dx) + $unsigned(dy * dy);
    if (d2 < 13'd576) begin
      shade_f = 8'd255 - d2[9:2];
    end else begin
      shade_f = 8'd0;
    end
  endfunction

  assign hit_s     = (wbs_adr_i[31:4] == 28'h3000000);
  assign req_s     = wbs_cyc_i & wbs_stb_i & ~ack_r;
  assign wr_ctrl_s = ack_r & wbs_cyc_i & wbs_stb_i & wbs_we_i & hit_s & (wbs_adr_i[3:2] == 2'd0);
  assign start_s   = wr_ctrl_s & wbs_dat_i[0] & (state_r != ST_RUN);
  assign pix_s     = start_s ? 12'd0 : idx_r[11:0];
  assign color_s   = shade_f(pix_s);
  assign unused_s  = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:1]};

  // Register read mux.
  always_comb begin
    rd_s = 32'd0;
    if (hit_s) begin
      case (wbs_adr_i[3:2])
        2'd1:    rd_s = {30'd0, (state_r == ST_DONE), (state_r == ST_RUN)};
        2'd2:    rd_s = {19'd0, idx_r};
        default: rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  // Next state and strobe decision; pixel 0 strobes on the start edge itself.
  always_comb begin
    state_nx_s = state_r;
    emit_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          state_nx_s = ST_RUN;
          emit_s     = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_RUN: begin
        if (idx_r == LAST) begin
          state_nx_s = ST_DONE;
        end else if (div_r == 8'd0) begin
          emit_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Raster index (next pixel to emit, doubles as COUNT) and strobe divider.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      idx_r <= 13'd0;
      div_r <= 8'd0;
    end else if (start_s) begin
      idx_r <= 13'd1;
      div_r <= RELOAD;
    end else if (emit_s) begin
      idx_r <= idx_r + 13'd1;
      div_r <= RELOAD;
    end else if ((state_r == ST_RUN) && (div_r != 8'd0)) begin
      div_r <= div_r - 8'd1;
    end else begin
      div_r <= div_r;
    end
  end

  // Pad outputs: color holds between strobes, pixel_write pulses.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      io_r <= 9'd0;
    end else if (emit_s) begin
      io_r <= {1'b1, color_s};
    end else begin
      io_r <= {1'b0, io_r[7:0]};
    end
  end

  // Wishbone acknowledge and read data, one cycle after the request.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
    end else begin
      ack_r <= req_s;
      dat_r <= req_s ? rd_s : 32'd0;
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign io_out    = io_r;
  assign io_oeb    = 9'd0;

endmodule

// File: tb/tb_gonso_pixel_renderer.sv
// Directed/randomized bench for gonso_pixel_renderer with a pixel-level reference model.
module tb_gonso_pixel_renderer;
  localparam int CPP = 4;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_CNT  = 32'h3000_0008;
  localparam logic [31:0] A_RSV  = 32'h3000_000C;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [8:0]  io_out, io_oeb;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int m_idx = 4096;
  int m_start = 0;
  int m_sum = 0;
  bit m_active = 1'b0;
  logic [7:0] got [4096];

  gonso_pixel_renderer #(.CLKS_PER_PIXEL(CPP)) dut (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .io_out(io_out), .io_oeb(io_oeb)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Disc shade straight from the geometric definition.
  function automatic int exp_color(input int k);
    int dx, dy, d2;
    dx = (k % 64) - 32;
    dy = (k / 64) - 32;
    d2 = dx * dx + dy * dy;
    return (d2 < 576) ? 255 - d2 / 4 : 0;
  endfunction

  function automatic bit model_running();
    return m_active && (m_idx < 4096);
  endfunction

  // Strobe monitor: every strobe must be the next expected pixel at its exact cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (resetb && io_out[8]) begin
        if (model_running()) begin
          check("pix_color", {24'd0, io_out[7:0]}, exp_color(m_idx));
          check("pix_cycle", cyc_cnt, m_start + 1 + m_idx * CPP);
          got[m_idx] = io_out[7:0];
          m_sum += int'(io_out[7:0]);
          m_idx++;
        end else begin
          check("extra_strobe", {31'd0, io_out[8]}, 32'd0);
        end
      end
    end
  end

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    output logic [31:0] rd);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat;
    @(negedge clock);
    check("ack_rise", {31'd0, wbs_ack_o}, 32'd1);
    rd = wbs_dat_o;
    if (we && adr == A_CTRL && dat[0] && !model_running()) begin
      m_start = cyc_cnt; m_idx = 0; m_sum = 0; m_active = 1'b1;
    end
    @(negedge clock);
    check("ack_pulse", {31'd0, wbs_ack_o}, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 4096 * CPP + 64 && m_idx < 4096; i++) @(negedge clock);
    check("frame_len", m_idx, 32'd4096);
    repeat (3 * CPP) @(negedge clock);
    check("no_4097", m_idx, 32'd4096);
  endtask

  initial begin
    logic [31:0] rd, c1, c2;
    int ref_sum, sum1;
    ref_sum = 0;
    for (int k = 0; k < 4096; k++) ref_sum += exp_color(k);

    // Reset state
    repeat (10) @(negedge clock);
    check("rst_io", {23'd0, io_out}, 32'd0);
    check("rst_oeb", {23'd0, io_oeb}, 32'd0);
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    resetb = 1'b1;
    wb(1'b0, A_STAT, 32'd0, rd); check("rst_status", rd, 32'h0);
    wb(1'b0, A_CNT, 32'd0, rd);  check("rst_count", rd, 32'd0);

    // Bus edge cases while idle
    wb(1'b0, A_RSV, 32'd0, rd);  check("rsv_read", rd, 32'd0);
    wb(1'b1, A_RSV, $urandom(), rd);
    wb(1'b1, A_CTRL, {$urandom_range(0, 32'h7FFF_FFFF), 1'b0}, rd);
    wb(1'b0, A_CTRL, 32'd0, rd); check("ctrl_read", rd, 32'd0);
    repeat (20) @(negedge clock);
    wb(1'b0, A_STAT, 32'd0, rd); check("no_start", rd, 32'h0);

    // Basic render
    wb(1'b1, A_CTRL, 32'd1, rd);
    wait_frame();
    check("px0", {24'd0, got[0]}, 32'd0);
    check("px2080", {24'd0, got[2080]}, 32'd255);
    check("px2088", {24'd0, got[2088]}, 32'd239);
    check("px2104", {24'd0, got[2104]}, 32'd0);
    check("sum_ref", m_sum, ref_sum);
    sum1 = m_sum;
    wb(1'b0, A_STAT, 32'd0, rd); check("done_status", rd, 32'h2);
    wb(1'b0, A_CNT, 32'd0, rd);  check("done_count", rd, 32'd4096);

    // Restart from DONE, with an ignored start around pixel 100
    wb(1'b1, A_CTRL, 32'd1, rd);
    wb(1'b0, A_STAT, 32'd0, rd); check("restart_busy", rd, 32'h1);
    for (int i = 0; i < 200 * CPP && m_idx < 100 + int'($urandom_range(0, 8)); i++)
      @(negedge clock);
    wb(1'b0, A_CNT, 32'd0, rd); c1 = rd;
    wb(1'b1, A_CTRL, 32'd1, rd);
    wb(1'b0, A_CNT, 32'd0, rd); c2 = rd;
    check("count_mono", {31'd0, c2 > c1}, 32'd1);
    wait_frame();
    check("sum_repeat", m_sum, sum1);

    // Reset in the middle of a run
    wb(1'b1, A_CTRL, 32'd1, rd);
    for (int i = 0; i < 2100 * CPP && m_idx < 2000 + int'($urandom_range(0, 20)); i++)
      @(negedge clock);
    @(posedge clock); #2;
    resetb = 1'b0;
    m_active = 1'b0;
    #1;
    check("midrst_io", {23'd0, io_out}, 32'd0);
    check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    wb(1'b0, A_STAT, 32'd0, rd); check("midrst_status", rd, 32'h0);
    wb(1'b0, A_CNT, 32'd0, rd);  check("midrst_count", rd, 32'd0);
    repeat (20) @(negedge clock);
    wb(1'b1, A_CTRL, 32'd1, rd);
    wait_frame();
    check("sum_after_rst", m_sum, sum1);
    wb(1'b0, A_STAT, 32'd0, rd); check("final_status", rd, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gonso_pixel_renderer.md
# gonso_pixel_renderer

User-area pixel renderer that sits inside the Caravel user project wrapper, between the management SoC's Wishbone bus and the mprj_io pads. On a firmware start command it rasterizes a fixed 64x64 shaded-disc image and streams one 8-bit grayscale pixel at a time onto mprj_io[7:0], with a one-cycle strobe on mprj_io[8]. Firmware polls a status register and reports progress on mprj_io[31:16], which are management-owned.

## Interface
- CLKS_PER_PIXEL, default 4: cycles between pixel strobes, range 1..255.
- clock  in  1  system clock (Caravel wb_clk_i).
- resetb  in  1  reset; one clock; reset is asynchronous and active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control.
- wbs_sel_i  in  4  byte selects; ignored, full-word access.
- wbs_adr_i  in  32  byte address; decoded on bits [3:2] when [31:4] == 0x3000000.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  9  [7:0] color, [8] pixel_write.
- io_oeb  out  9  output enables, active-low; constant 0 (driven).

## Operation
- Registers:
  - 0x30000000 CTRL: write bit0=1 issues start. Reads 0.
  - 0x30000004 STATUS (RO): bit0 busy, bit1 done.
  - 0x30000008 COUNT (RO): pixels emitted since last start, 0..4096.
  - 0x3000000C: reads 0, writes ignored.
- States:
  - IDLE: waiting for start.
  - RUN: emitting pixels.
  - DONE: image complete.
- Transitions:
  - IDLE or DONE --start--> RUN. x=y=0, COUNT=0, done cleared.
  - Start while in RUN is ignored.
- Raster order: x counts 0..63 fastest, then y 0..63. Pixel index = y*64+x.
- Pixel value, with dx = x-32 and dy = y-32 (signed 7-bit), d2 = dx*dx + dy*dy (unsigned 13-bit):
  - d2 < 576: color = 255 - (d2 >> 2). Range 112..255.
  - otherwise: color = 0.
- On each strobe cycle: pixel_write=1, color = value for the current (x,y), COUNT increments.
- color holds its last value between strobes. pixel_write is 0 except on strobe cycles.
- After the strobe for pixel 4095, the state goes to DONE. COUNT stays 4096.

## Timing
- Wishbone:
  - ack is asserted exactly one cycle after a cycle with cyc&stb and ack low. It is a single-cycle pulse.
  - Read data is valid in the ack cycle. Back-to-back accesses take 2 cycles each.
- A start write is accepted in the ack cycle A. State is RUN at A+1.
- Pixel k strobes at cycle A+1+k*CLKS_PER_PIXEL.
- DONE at A+2+4095*CLKS_PER_PIXEL. From that cycle busy=0 and done=1.
- CLKS_PER_PIXEL=1 gives a continuous strobe for 4096 cycles.
- Reset values: io_out=0, io_oeb=0, wbs_ack_o=0, wbs_dat_o=0, state IDLE, COUNT=0, busy=0, done=0.
- Reset asserted mid-RUN:
  - All of the above apply immediately (asynchronous).
  - No further strobes until a new start.
- Boundary cases:
  - The x wrap 63->0 increments y in the same cycle.
  - The y wrap after pixel 4095 ends the run. No 4097th strobe.

## Test plan
- Reset: hold resetb=0 for 10 cycles, then release. io_out=0, STATUS reads 0x0, COUNT reads 0, io_oeb=0.
- Basic render, CLKS_PER_PIXEL=4:
  - Write CTRL=1.
  - Exactly 4096 strobes, spaced 4 cycles apart.
  - Pixel 0 color=0. Pixel (32,32), index 2080, color=255. Pixel (40,32) color=239. Pixel (56,32) color=0 (d2=576).
  - STATUS then reads 0x2, COUNT reads 4096.
- Restart from DONE: write CTRL=1 again. busy=1 and done=0 next cycle. A second identical 4096-pixel stream follows, and its checksum matches the first.
- Start during RUN: write CTRL=1 at pixel ~100. No restart, COUNT keeps increasing monotonically, total strobes = 4096.
- Reset mid-run at pixel ~2000: io_out goes to 0 immediately, STATUS reads 0. A new start produces a full frame from pixel 0.
- Bus edge cases:
  - Read 0x3000000C returns 0.
  - Write CTRL=0 does not start.
  - Every access is acked exactly once, 1 cycle after the request.
